collision_scanner: RTL and testbench

Parametrised per-frame collision engine between NUM_ENTITIES movable objects (player, sword, sheep, …) and an NUM_SEGMENTS-long dragon body. On a frame_start pulse it snapshots all positions, scans one dragon segment per clock, and reports per-entity collision flags plus the lowest colliding segment index with a one-cycle done pulse. It sits between the entity/dragon position logic and the game state controller. Because positions are frozen for the whole scan, motion during a scan cannot corrupt the result.

---
 rtl/collision_pkg.sv | 22 ++
 rtl/segment_match.sv | 24 ++
 rtl/collision_scanner.sv | 151 +++++++++++++++
 tb/tb_collision_scanner.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Shared types and constants for the dragon collision scanner.
package collision_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int unsigned DEF_NUM_SEGMENTS = 7;
    localparam int unsigned DEF_NUM_ENTITIES = 3;
    localparam int unsigned DEF_POS_W        = 8;

    localparam int unsigned PLAYER = 0;
    localparam int unsigned SWORD  = 1;
    localparam int unsigned SHEEP  = 2;

    // Segment index width; a single-segment dragon still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/segment_match.sv
// Compares every entity against one dragon segment; invalid entities and
// inactive segments never match.
module segment_match
    import collision_pkg::*;
#(
    parameter int unsigned NUM_ENTITIES = DEF_NUM_ENTITIES,
    parameter int unsigned POS_W        = DEF_POS_W
) (
    input  logic [NUM_ENTITIES*POS_W-1:0] entity_pos,
    input  logic [NUM_ENTITIES-1:0]       entity_valid,
    input  logic [POS_W-1:0]              seg_pos,
    input  logic                          seg_active,
    output logic [NUM_ENTITIES-1:0]       match_c
);

    always_comb begin
        match_c = '0;
        for (int unsigned e = 0; e < NUM_ENTITIES; e++) begin
            match_c[e] = entity_valid[e] & seg_active &
                         (entity_pos[e*POS_W +: POS_W] == seg_pos);
        end
    end

endmodule

// File: rtl/collision_scanner.sv
// Per-frame collision engine: snapshots positions on frame_start, then scans
// one dragon segment per clock and publishes all results together with done.
module collision_scanner
    import collision_pkg::*;
#(
    parameter int unsigned NUM_SEGMENTS = DEF_NUM_SEGMENTS,
    parameter int unsigned NUM_ENTITIES = DEF_NUM_ENTITIES,
    parameter int unsigned POS_W        = DEF_POS_W,
    parameter int unsigned IDX_W        = idx_width(NUM_SEGMENTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic [NUM_ENTITIES*POS_W-1:0] entity_pos,
    input  logic [NUM_ENTITIES-1:0]       entity_valid,
    input  logic [NUM_SEGMENTS*POS_W-1:0] segment_pos,
    input  logic [NUM_SEGMENTS-1:0]       segment_active,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_ENTITIES-1:0]       collision,
    output logic [NUM_ENTITIES*IDX_W-1:0] hit_idx,
    output logic                          overrun
);

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                seg_cnt_q, seg_cnt_d;
    logic [NUM_ENTITIES-1:0]         acc_hit_q, acc_hit_d;
    logic [NUM_ENTITIES*IDX_W-1:0]   acc_idx_q, acc_idx_d;
    logic                            busy_d, done_d, overrun_d;
    logic [NUM_ENTITIES-1:0]         collision_d;
    logic [NUM_ENTITIES*IDX_W-1:0]   hit_idx_d;
    logic                            capture_c;

    logic [NUM_ENTITIES*POS_W-1:0]   entity_pos_q;
    logic [NUM_ENTITIES-1:0]         entity_valid_q;
    logic [POS_W-1:0]                seg_pos_q [NUM_SEGMENTS];
    logic [NUM_SEGMENTS-1:0]         segment_active_q;

    logic [POS_W-1:0]                seg_pos_cur_c;
    logic                            seg_active_cur_c;
    logic [NUM_ENTITIES-1:0]         match_c;
    logic [NUM_ENTITIES-1:0]         hit_next_c;
    logic [NUM_ENTITIES*IDX_W-1:0]   idx_next_c;

    assign seg_pos_cur_c    = seg_pos_q[seg_cnt_q];
    assign seg_active_cur_c = segment_active_q[seg_cnt_q];

    segment_match #(
        .NUM_ENTITIES (NUM_ENTITIES),
        .POS_W        (POS_W)
    ) u_match (
        .entity_pos   (entity_pos_q),
        .entity_valid (entity_valid_q),
        .seg_pos      (seg_pos_cur_c),
        .seg_active   (seg_active_cur_c),
        .match_c      (match_c)
    );

    // First match wins: an entity already hit keeps its earlier index.
    always_comb begin
        hit_next_c = acc_hit_q;
        idx_next_c = acc_idx_q;
        for (int unsigned e = 0; e < NUM_ENTITIES; e++) begin
            if (match_c[e] && !acc_hit_q[e]) begin
                hit_next_c[e]                = 1'b1;
                idx_next_c[e*IDX_W +: IDX_W] = seg_cnt_q;
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        seg_cnt_d   = seg_cnt_q;
        acc_hit_d   = acc_hit_q;
        acc_idx_d   = acc_idx_q;
        busy_d      = busy;
        done_d      = 1'b0;
        overrun_d   = 1'b0;
        collision_d = collision;
        hit_idx_d   = hit_idx;
        capture_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    capture_c = 1'b1;
                    acc_hit_d = '0;
                    acc_idx_d = '0;
                    seg_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                overrun_d = frame_start;
                acc_hit_d = hit_next_c;
                acc_idx_d = idx_next_c;
                if (seg_cnt_q == IDX_W'(NUM_SEGMENTS - 1)) begin
                    collision_d = hit_next_c;
                    hit_idx_d   = idx_next_c;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    seg_cnt_d = seg_cnt_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            seg_cnt_q        <= '0;
            acc_hit_q        <= '0;
            acc_idx_q        <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            overrun          <= 1'b0;
            collision        <= '0;
            hit_idx          <= '0;
            entity_pos_q     <= '0;
            entity_valid_q   <= '0;
            segment_active_q <= '0;
            for (int unsigned s = 0; s < NUM_SEGMENTS; s++) begin
                seg_pos_q[s] <= '0;
            end
        end else begin
            state_q   <= state_d;
            seg_cnt_q <= seg_cnt_d;
            acc_hit_q <= acc_hit_d;
            acc_idx_q <= acc_idx_d;
            busy      <= busy_d;
            done      <= done_d;
            overrun   <= overrun_d;
            collision <= collision_d;
            hit_idx   <= hit_idx_d;
            if (capture_c) begin
                entity_pos_q     <= entity_pos;
                entity_valid_q   <= entity_valid;
                segment_active_q <= segment_active;
                for (int unsigned s = 0; s < NUM_SEGMENTS; s++) begin
                    seg_pos_q[s] <= segment_pos[s*POS_W +: POS_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_collision_scanner.sv
// Bench for collision_scanner: default 7x3 instance plus a 16x5 instance.
module tb_collision_scanner;

    logic clk;
    logic reset;

    logic        fs_a, busy_a, done_a, ovr_a;
    logic [23:0] ep_a;
    logic [2:0]  ev_a, coll_a;
    logic [55:0] sp_a;
    logic [6:0]  sa_a;
    logic [8:0]  hit_a;

    logic         fs_b, busy_b, done_b, ovr_b;
    logic [39:0]  ep_b;
    logic [4:0]   ev_b, coll_b;
    logic [127:0] sp_b;
    logic [15:0]  sa_b;
    logic [19:0]  hit_b;

    typedef struct packed {
        logic [4:0]  coll;
        logic [19:0] hit;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   total = 0;
    int   bad   = 0;

    collision_scanner dut_a (
        .clk(clk), .reset(reset), .frame_start(fs_a),
        .entity_pos(ep_a), .entity_valid(ev_a),
        .segment_pos(sp_a), .segment_active(sa_a),
        .busy(busy_a), .done(done_a), .collision(coll_a),
        .hit_idx(hit_a), .overrun(ovr_a)
    );

    collision_scanner #(.NUM_SEGMENTS(16), .NUM_ENTITIES(5), .POS_W(8), .IDX_W(4)) dut_b (
        .clk(clk), .reset(reset), .frame_start(fs_b),
        .entity_pos(ep_b), .entity_valid(ev_b),
        .segment_pos(sp_b), .segment_active(sa_b),
        .busy(busy_b), .done(done_b), .collision(coll_b),
        .hit_idx(hit_b), .overrun(ovr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic default_a();
        for (int s = 0; s < 7; s++) sp_a[s*8 +: 8] = 8'(16 + s);
        sa_a = '1;
    endtask

    // Fires one frame on dut_a; optional mid-scan player change and re-fire.
    task automatic scan_a(input int chg_at, input logic [7:0] chg_val, input int refire_at,
                          output int k_done, output int n_ovr, output int ovr_k,
                          output int busy_err);
        k_done = -1; n_ovr = 0; ovr_k = -1; busy_err = 0;
        @(negedge clk);
        fs_a = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            fs_a = (k == refire_at);
            if (k == chg_at) ep_a[7:0] = chg_val;
            if (ovr_a === 1'b1) begin n_ovr++; ovr_k = k; end
            if (k <= 7 && busy_a !== 1'b1) busy_err++;
            if (done_a === 1'b1) begin k_done = k; break; end
        end
        fs_a = 1'b0;
    endtask

    task automatic check_frame_a(input string name, input int k_done, input int busy_err);
        exp_t ex;
        total++;
        if (k_done != 8) begin
            bad++; $display("FAIL %s latency: done at cycle %0d, want 8", name, k_done);
        end
        total++;
        if (busy_err != 0 || busy_a !== 1'b0) begin
            bad++; $display("FAIL %s busy: %0d bad busy cycles, busy at done=%b, want 0/0", name, busy_err, busy_a);
        end
        total++;
        if (sb_a.size() == 0) begin
            bad++; $display("FAIL %s scoreboard: queue empty, want one entry", name);
        end else begin
            ex = sb_a.pop_front();
            total++;
            if (coll_a !== ex.coll[2:0]) begin
                bad++; $display("FAIL %s collision: got %b want %b", name, coll_a, ex.coll[2:0]);
            end
            total++;
            if (hit_a !== ex.hit[8:0]) begin
                bad++; $display("FAIL %s hit_idx: got %h want %h", name, hit_a, ex.hit[8:0]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        fs_a = 0; ep_a = '0; ev_a = '0; sp_a = '0; sa_a = '0;
        fs_b = 0; ep_b = '0; ev_b = '0; sp_b = '0; sa_b = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy_a, done_a, ovr_a} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl_a: got %b want 000", {busy_a, done_a, ovr_a});
        end
        total++;
        if ({coll_a, hit_a} !== 12'h000) begin
            bad++; $display("FAIL reset_result_a: got %h want 000", {coll_a, hit_a});
        end
        total++;
        if ({busy_b, done_b, ovr_b, coll_b, hit_b} !== 28'h0) begin
            bad++; $display("FAIL reset_b: got %h want 0", {busy_b, done_b, ovr_b, coll_b, hit_b});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (busy_a !== 1'b0) begin
            bad++; $display("FAIL idle_busy: got %b want 0", busy_a);
        end
    endtask

    task automatic test_no_hit();
        int k, no, ok, be;
        ep_a = {8'h00, 8'h00, 8'h23}; ev_a = 3'b001; default_a();
        sb_a.push_back('{coll: 5'h0, hit: 20'h0});
        scan_a(-1, 8'h00, -1, k, no, ok, be);
        check_frame_a("no_hit", k, be);
        total++;
        if (no != 0) begin
            bad++; $display("FAIL no_hit overrun: got %0d pulses want 0", no);
        end
        @(negedge clk);
        total++;
        if (done_a !== 1'b0) begin
            bad++; $display("FAIL done_pulse_width: got %b want 0", done_a);
        end
    endtask

    task automatic test_snapshot();
        int k, no, ok, be;
        ep_a = {8'h00, 8'h00, 8'h23}; ev_a = 3'b001; default_a();
        sb_a.push_back('{coll: 5'h0, hit: 20'h0});
        scan_a(2, 8'h12, 3, k, no, ok, be);
        check_frame_a("snapshot", k, be);
        total++;
        if (no != 1 || ok != 4) begin
            bad++; $display("FAIL overrun: got %0d pulses at cycle %0d want 1 at cycle 4", no, ok);
        end
    endtask

    task automatic test_multi_hit();
        int k, no, ok, be;
        ep_a = {8'h13, 8'h00, 8'h13}; ev_a = 3'b101; default_a();
        sp_a[5*8 +: 8] = 8'h13;
        sb_a.push_back('{coll: 5'b00101, hit: 20'h0C3});
        scan_a(-1, 8'h00, -1, k, no, ok, be);
        check_frame_a("multi_hit", k, be);
    endtask

    task automatic test_inactive();
        int k, no, ok, be;
        ep_a = {8'h00, 8'h15, 8'h00}; ev_a = 3'b010; default_a();
        sa_a[5] = 1'b0;
        sb_a.push_back('{coll: 5'h0, hit: 20'h0});
        scan_a(-1, 8'h00, -1, k, no, ok, be);
        check_frame_a("inactive_seg", k, be);
        sa_a = '1;
        sb_a.push_back('{coll: 5'b00010, hit: 20'h028});
        scan_a(-1, 8'h00, -1, k, no, ok, be);
        check_frame_a("active_seg", k, be);
        sa_a = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({coll_a, hit_a} !== {3'b010, 9'h028}) begin
            bad++; $display("FAIL result_hold: got %h want %h", {coll_a, hit_a}, {3'b010, 9'h028});
        end
    endtask

    task automatic test_reset_mid_scan();
        int k, no, ok, be, ndone;
        ep_a = {8'h13, 8'h00, 8'h13}; ev_a = 3'b101; default_a();
        sp_a[5*8 +: 8] = 8'h13;
        @(negedge clk);
        fs_a = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            fs_a = 1'b0;
        end
        reset = 1'b0;
        #1;
        total++;
        if ({busy_a, done_a, ovr_a} !== 3'b000) begin
            bad++; $display("FAIL midreset_ctrl: got %b want 000", {busy_a, done_a, ovr_a});
        end
        total++;
        if ({coll_a, hit_a} !== 12'h000) begin
            bad++; $display("FAIL midreset_result: got %h want 000", {coll_a, hit_a});
        end
        ndone = 0;
        repeat (3) begin @(negedge clk); if (done_a === 1'b1) ndone++; end
        reset = 1'b1;
        repeat (10) begin @(negedge clk); if (done_a === 1'b1) ndone++; end
        total++;
        if (ndone != 0 || busy_a !== 1'b0) begin
            bad++; $display("FAIL aborted_scan: %0d done pulses busy=%b want 0/0", ndone, busy_a);
        end
        sb_a.push_back('{coll: 5'b00101, hit: 20'h0C3});
        scan_a(-1, 8'h00, -1, k, no, ok, be);
        check_frame_a("after_reset", k, be);
    endtask

    task automatic test_back_to_back();
        exp_t ex;
        int   ndone, novr;
        for (int s = 0; s < 16; s++) sp_b[s*8 +: 8] = 8'(64 + s);
        sa_b = '1;
        ep_b = {8'h4F, 8'h93, 8'h92, 8'h91, 8'h90};
        ev_b = '1;
        ndone = 0; novr = 0;
        @(negedge clk);
        fs_b = 1'b1;
        sb_b.push_back('{coll: 5'b10000, hit: 20'hF0000});
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            fs_b = 1'b0;
            if (ovr_b === 1'b1) novr++;
            if (done_b === 1'b1) begin
                ndone++;
                total++;
                if (k != ((ndone == 1) ? 17 : 34)) begin
                    bad++; $display("FAIL b2b latency %0d: done at cycle %0d want %0d", ndone, k, (ndone == 1) ? 17 : 34);
                end
                total++;
                if (sb_b.size() == 0) begin
                    bad++; $display("FAIL b2b scoreboard: queue empty, want one entry");
                end else begin
                    ex = sb_b.pop_front();
                    total++;
                    if ({coll_b, hit_b} !== {ex.coll, ex.hit}) begin
                        bad++; $display("FAIL b2b result %0d: got %b/%h want %b/%h", ndone, coll_b, hit_b, ex.coll, ex.hit);
                    end
                end
                if (ndone == 1) begin
                    ep_b[7:0]        = 8'h40;
                    ep_b[23:16]      = 8'h45;
                    sp_b[9*8 +: 8]   = 8'h45;
                    fs_b             = 1'b1;
                    sb_b.push_back('{coll: 5'b10101, hit: 20'hF0500});
                end else begin
                    break;
                end
            end
        end
        fs_b = 1'b0;
        total++;
        if (ndone != 2 || novr != 0) begin
            bad++; $display("FAIL b2b count: %0d dones %0d overruns want 2/0", ndone, novr);
        end
    endtask

    initial begin
        test_reset();
        test_no_hit();
        test_snapshot();
        test_multi_hit();
        test_inactive();
        test_reset_mid_scan();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
